fpu_add_pipe: RTL

//  Multi-cycle IEEE-754 adder/subtractor with a valid/ready handshake at both ports.

---
 rtl/fpu_add_pipe.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/fpu_add_pipe.sv
// Multi-cycle IEEE-754 adder/subtractor with valid/ready handshakes.
// Pipeline of FSM steps: IDLE -> ALIGN -> ADD -> NORM -> ROUND -> HOLD.
// Subnormal operands and results are flushed to zero; rounding is RNE.
//
// Handshake: an input transfer happens on a rising edge where
// in_valid && in_ready; in_ready is high only in IDLE. An output transfer
// happens on a rising edge where out_valid && out_ready; result and flags
// are held stable while out_valid is high and the consumer has not taken them.
module fpu_add_pipe #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   op,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic [2:0]             flags,
    output logic [2:0]             dbg_state
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int SW = MAN_W + 4;          // hidden bit, mantissa, guard, round, sticky
    localparam int EW = EXP_W + 2;          // exponent arithmetic with headroom
    localparam logic [EXP_W-1:0] EXP_MAX = '1;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ALIGN = 3'd1;
    localparam logic [2:0] ADD   = 3'd2;
    localparam logic [2:0] NORM  = 3'd3;
    localparam logic [2:0] ROUND = 3'd4;
    localparam logic [2:0] HOLD  = 3'd5;

    logic [2:0]     st;
    logic [W-1:0]   ra, rb;

    // ALIGN-stage registers (stay valid for the rest of the transaction)
    logic             al_sx, al_sub, al_spec, al_negz;
    logic [EXP_W-1:0] al_ex;
    logic [SW-1:0]    al_mx, al_my;
    logic [W-1:0]     al_spec_res;
    logic [2:0]       al_spec_flg;

    // ADD / NORM stage registers
    logic [SW:0]      sum_r;
    logic [SW-1:0]    nm_r;
    logic [EW-1:0]    ne_r;
    logic             zero_r, ftz_r, zsign_r;

    assign in_ready  = (st == IDLE);
    assign dbg_state = st;

    // ALIGN: unpack, resolve specials, order by magnitude, shift the smaller operand
    logic             sa, sb, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, swap;
    logic [EXP_W-1:0] ea, eb, ex_c, ey_c;
    logic [MAN_W-1:0] fa, fb;
    logic [W-2:0]     amag, bmag;
    logic [SW-1:0]    mx_c, yext_c, my_c, shifted_c;
    logic [EW-1:0]    diff_c;
    logic             lost_c, sx_c, sy_c, spec_c;
    logic [W-1:0]     spec_res_c;
    logic [2:0]       spec_flg_c;
    always_comb begin
        sa = ra[W-1];  ea = ra[W-2:MAN_W];  fa = ra[MAN_W-1:0];
        sb = rb[W-1];  eb = rb[W-2:MAN_W];  fb = rb[MAN_W-1:0];
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        a_inf  = (ea == EXP_MAX) && (fa == '0);
        b_inf  = (eb == EXP_MAX) && (fb == '0);
        a_nan  = (ea == EXP_MAX) && (fa != '0);
        b_nan  = (eb == EXP_MAX) && (fb != '0);
        amag   = a_zero ? '0 : {ea, fa};
        bmag   = b_zero ? '0 : {eb, fb};
        swap   = (bmag > amag);
        sx_c   = swap ? sb : sa;
        sy_c   = swap ? sa : sb;
        ex_c   = swap ? eb : ea;
        ey_c   = swap ? ea : eb;
        mx_c   = '0;
        yext_c = '0;
        if (swap) begin
            if (!b_zero) mx_c   = {1'b1, fb, 3'b000};
            if (!a_zero) yext_c = {1'b1, fa, 3'b000};
        end else begin
            if (!a_zero) mx_c   = {1'b1, fa, 3'b000};
            if (!b_zero) yext_c = {1'b1, fb, 3'b000};
        end
        diff_c    = EW'(ex_c) - EW'(ey_c);
        shifted_c = yext_c >> diff_c;
        lost_c    = 1'b0;
        for (int i = 0; i < SW; i++) begin
            if (EW'(i) < diff_c) lost_c = lost_c | yext_c[i];
        end
        if (diff_c >= EW'(SW - 1)) my_c = {{(SW-1){1'b0}}, |yext_c};
        else                       my_c = {shifted_c[SW-1:1], shifted_c[0] | lost_c};
        spec_c     = 1'b1;
        spec_res_c = '0;
        spec_flg_c = 3'b000;
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
            spec_res_c = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};
            spec_flg_c = 3'b100;
        end else if (a_inf) begin
            spec_res_c = {sa, EXP_MAX, {MAN_W{1'b0}}};
        end else if (b_inf) begin
            spec_res_c = {sb, EXP_MAX, {MAN_W{1'b0}}};
        end else begin
            spec_c = 1'b0;
        end
    end

    // ADD: magnitude sum or difference (X >= Y, so no negative result)
    logic [SW:0] sum_c;
    always_comb begin
        if (al_sub) sum_c = {1'b0, al_mx} - {1'b0, al_my};
        else        sum_c = {1'b0, al_mx} + {1'b0, al_my};
    end

    // NORM: single-cycle normalisation with leading-zero count and flush-to-zero
    logic [EW-1:0] lzc_c, ne_c;
    logic [SW-1:0] nm_c;
    logic          found_c, zero_c, ftz_c, zsign_c;
    always_comb begin
        lzc_c   = '0;
        found_c = 1'b0;
        for (int i = SW - 1; i >= 0; i--) begin
            if (!found_c && sum_r[i]) begin
                lzc_c   = EW'(SW - 1 - i);
                found_c = 1'b1;
            end
        end
        nm_c    = '0;
        ne_c    = '0;
        zero_c  = 1'b0;
        ftz_c   = 1'b0;
        zsign_c = 1'b0;
        if (sum_r[SW]) begin
            nm_c = {sum_r[SW:2], sum_r[1] | sum_r[0]};
            ne_c = EW'(al_ex) + EW'(1);
        end else if (sum_r == '0) begin
            zero_c  = 1'b1;
            zsign_c = al_negz;
        end else if (EW'(al_ex) <= lzc_c) begin
            zero_c  = 1'b1;
            ftz_c   = 1'b1;
            zsign_c = al_sx;
        end else begin
            nm_c = sum_r[SW-1:0] << lzc_c;
            ne_c = EW'(al_ex) - lzc_c;
        end
    end

    // ROUND: round-to-nearest-even, renormalise, overflow to infinity
    logic                 g_c, r_c, s_c, inc_c;
    logic [MAN_W+1:0]     mr_c;
    logic [EW-1:0]        er_c;
    logic [W-1:0]         res_c;
    logic [2:0]           flg_c;
    logic                 unused_hidden;
    always_comb begin
        g_c   = nm_r[2];
        r_c   = nm_r[1];
        s_c   = nm_r[0];
        inc_c = g_c & (r_c | s_c | nm_r[3]);
        mr_c  = {1'b0, nm_r[SW-1:3]} + {{(MAN_W+1){1'b0}}, inc_c};
        er_c  = ne_r;
        if (mr_c[MAN_W+1]) begin
            mr_c = mr_c >> 1;
            er_c = ne_r + EW'(1);
        end
        if (al_spec) begin
            res_c = al_spec_res;
            flg_c = al_spec_flg;
        end else if (zero_r) begin
            res_c = {zsign_r, {(W-1){1'b0}}};
            flg_c = {2'b00, ftz_r};
        end else if (er_c >= EW'(EXP_MAX)) begin
            res_c = {al_sx, EXP_MAX, {MAN_W{1'b0}}};
            flg_c = 3'b011;
        end else begin
            res_c = {al_sx, er_c[EXP_W-1:0], mr_c[MAN_W-1:0]};
            flg_c = {2'b00, g_c | r_c | s_c};
        end
    end
    assign unused_hidden = mr_c[MAN_W];

    // Control FSM: one state per cycle, waits in IDLE and HOLD
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= IDLE;
            out_valid <= 1'b0;
        end else begin
            case (st)
                IDLE:  if (in_valid) st <= ALIGN;
                ALIGN: st <= ADD;
                ADD:   st <= NORM;
                NORM:  st <= ROUND;
                ROUND: st <= HOLD;
                HOLD: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        st        <= IDLE;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

    // Datapath registers, each loaded in the state that produces it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ra <= '0;  rb <= '0;
            al_sx <= 1'b0;  al_sub <= 1'b0;  al_spec <= 1'b0;  al_negz <= 1'b0;
            al_ex <= '0;  al_mx <= '0;  al_my <= '0;
            al_spec_res <= '0;  al_spec_flg <= '0;
            sum_r <= '0;  nm_r <= '0;  ne_r <= '0;
            zero_r <= 1'b0;  ftz_r <= 1'b0;  zsign_r <= 1'b0;
            result <= '0;  flags <= '0;
        end else begin
            if (st == IDLE && in_valid) begin
                ra <= a;
                rb <= {b[W-1] ^ op, b[W-2:0]};
            end
            if (st == ALIGN) begin
                al_sx       <= sx_c;
                al_sub      <= (sx_c != sy_c);
                al_ex       <= ex_c;
                al_mx       <= mx_c;
                al_my       <= my_c;
                al_spec     <= spec_c;
                al_spec_res <= spec_res_c;
                al_spec_flg <= spec_flg_c;
                al_negz     <= sa & sb & a_zero & b_zero;
            end
            if (st == ADD) sum_r <= sum_c;
            if (st == NORM) begin
                nm_r    <= nm_c;
                ne_r    <= ne_c;
                zero_r  <= zero_c;
                ftz_r   <= ftz_c;
                zsign_r <= zsign_c;
            end
            if (st == ROUND) begin
                result <= res_c;
                flags  <= flg_c;
            end
        end
    end

endmodule
